// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed driver for a 4-digit, 7-segment display.
// Each digit is held for CLKS_PER_DIGIT cycles and the digits are scanned 0..3.
// A shadow register captures new data at any time. The display register
// follows the shadow only at frame boundaries, so a frame never tears.
// Optional feature: define SEG_SCAN_BLANK_EN to blank leading zeros on
// digits 3..1. Digit 0 is never blanked.
module seg_scan_ctrl #(
  parameter int CLKS_PER_DIGIT = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] din,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(CLKS_PER_DIGIT - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_tick, w_tick_nxt;
  logic [1:0]  r_digit, w_digit_nxt;
  logic [15:0] r_shadow, w_shadow_nxt;
  logic [15:0] r_disp, w_disp_nxt;
  logic [6:0]  r_seg, w_seg_nxt;
  logic [3:0]  r_an, w_an_nxt;
  logic        r_fd, w_fd_nxt;

  // Hex nibble to active-high segment pattern {a,b,c,d,e,f,g}.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      4'hF:    s = 7'b1000111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Segment pattern for digit idx of a display word, with optional blanking.
  function automatic logic [6:0] f_digit_seg(input logic [15:0] disp, input logic [1:0] idx);
    logic [6:0] s;
    s = f_decode(disp[{idx, 2'b00} +: 4]);
`ifdef SEG_SCAN_BLANK_EN
    case (idx)
      2'd3:    if (disp[15:12] == 4'h0) s = 7'b0000000;
      2'd2:    if (disp[15:8] == 8'h00) s = 7'b0000000;
      2'd1:    if (disp[15:4] == 12'h000) s = 7'b0000000;
      default: s = s;
    endcase
`endif
    return s;
  endfunction

  // Next-state, counters, data registers and registered-output values.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_digit_nxt = r_digit;
    w_disp_nxt  = r_disp;
    w_seg_nxt   = r_seg;
    w_an_nxt    = r_an;
    w_fd_nxt    = 1'b0;
    if (load) begin
      w_shadow_nxt = din;
    end else begin
      w_shadow_nxt = r_shadow;
    end

    case (r_state)
      ST_IDLE: begin
        if (en) begin
          // Entering the scan: take the latest shadow and start at digit 0.
          w_state_nxt = ST_SCAN;
          w_tick_nxt  = 16'd0;
          w_digit_nxt = 2'd0;
          w_disp_nxt  = r_shadow;
          w_an_nxt    = 4'b0001;
          w_seg_nxt   = f_digit_seg(r_shadow, 2'd0);
        end else begin
          w_state_nxt = ST_IDLE;
          w_tick_nxt  = 16'd0;
          w_digit_nxt = 2'd0;
          w_an_nxt    = 4'b0000;
          w_seg_nxt   = 7'b0000000;
        end
      end
      ST_SCAN: begin
        if (!en) begin
          // Abandoning a partial frame: blank and never flag frame_done.
          w_state_nxt = ST_IDLE;
          w_tick_nxt  = 16'd0;
          w_digit_nxt = 2'd0;
          w_an_nxt    = 4'b0000;
          w_seg_nxt   = 7'b0000000;
        end else if (r_tick == TICK_LAST) begin
          w_tick_nxt  = 16'd0;
          w_digit_nxt = r_digit + 2'd1;
          if (r_digit == 2'd3) begin
            // Frame boundary: a same-cycle load goes straight to the display.
            w_disp_nxt = w_shadow_nxt;
            w_fd_nxt   = 1'b1;
          end else begin
            w_disp_nxt = r_disp;
          end
          w_an_nxt  = 4'b0001 << w_digit_nxt;
          w_seg_nxt = f_digit_seg(w_disp_nxt, w_digit_nxt);
        end else begin
          w_tick_nxt = r_tick + 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tick_nxt  = 16'd0;
        w_digit_nxt = 2'd0;
        w_an_nxt    = 4'b0000;
        w_seg_nxt   = 7'b0000000;
      end
    endcase
  end

  // State register and all datapath/output registers, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_tick   <= 16'd0;
      r_digit  <= 2'd0;
      r_shadow <= 16'h0000;
      r_disp   <= 16'h0000;
      r_seg    <= 7'b0000000;
      r_an     <= 4'b0000;
      r_fd     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tick   <= w_tick_nxt;
      r_digit  <= w_digit_nxt;
      r_shadow <= w_shadow_nxt;
      r_disp   <= w_disp_nxt;
      r_seg    <= w_seg_nxt;
      r_an     <= w_an_nxt;
      r_fd     <= w_fd_nxt;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with CLKS_PER_DIGIT=4.
// A frame-position reference model predicts an/seg/frame_done every cycle.
module tb_seg_scan_ctrl;

  localparam int CPD   = 4;
  localparam int FRAME = 4 * CPD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] din;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: scanning flag, position within frame, data words.
  bit          m_scan;
  int          m_pos;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic        m_fd;

  logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  seg_scan_ctrl #(.CLKS_PER_DIGIT(CPD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_an();
    if (!m_scan) return 4'b0000;
    return 4'b0001 << (m_pos / CPD);
  endfunction

  function automatic logic [6:0] exp_seg();
    int d;
    logic [15:0] upper;
    if (!m_scan) return 7'b0000000;
    d = m_pos / CPD;
    upper = m_disp >> (4 * d);
`ifdef SEG_SCAN_BLANK_EN
    if (d > 0 && upper == 16'h0000) return 7'b0000000;
`endif
    return seg_tab[upper[3:0]];
  endfunction

  task automatic model_reset();
    m_scan = 1'b0; m_pos = 0; m_disp = 16'h0000; m_shadow = 16'h0000; m_fd = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] sh_old;
    sh_old = m_shadow;
    if (!m_scan) begin
      m_fd = 1'b0;
      if (en) begin m_scan = 1'b1; m_pos = 0; m_disp = sh_old; end
    end else if (!en) begin
      m_scan = 1'b0; m_pos = 0; m_fd = 1'b0;
    end else if (m_pos == FRAME - 1) begin
      m_pos = 0; m_disp = load ? din : sh_old; m_fd = 1'b1;
    end else begin
      m_pos = m_pos + 1; m_fd = 1'b0;
    end
    if (load) m_shadow = din;
  endtask

  // One clock: the model consumes the inputs seen at the edge; outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; din = 16'h0000;
    model_reset();
    #2;
    checks++;
    if (an !== 4'b0000 || seg !== 7'b0000000 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state an=%b seg=%b fd=%b required 0000/0000000/0", an, seg, frame_done);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== m_fd) begin
        failures++;
        $display("FAIL idle_hold an=%b/%b seg=%b/%b fd=%b/%b", an, exp_an(), seg, exp_seg(), frame_done, m_fd);
      end
    end
  endtask

  task automatic test_scan_1234();
    logic [6:0] req [4] = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
    din = 16'h1234; load = 1'b1; tick(); load = 1'b0;
    en = 1'b1;
    for (int i = 0; i <= FRAME; i++) begin
      tick();
      checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== m_fd) begin
        failures++;
        $display("FAIL scan_model i=%0d an=%b/%b seg=%b/%b fd=%b/%b", i, an, exp_an(), seg, exp_seg(), frame_done, m_fd);
      end
      if (i < FRAME) begin
        checks++;
        if (an !== (4'b0001 << (i / CPD)) || seg !== req[i / CPD] || frame_done !== 1'b0) begin
          failures++;
          $display("FAIL scan_1234 i=%0d an=%b seg=%b fd=%b required seg=%b", i, an, seg, frame_done, req[i / CPD]);
        end
      end else begin
        checks++;
        if (frame_done !== 1'b1 || an !== 4'b0001) begin
          failures++;
          $display("FAIL scan_frame_done fd=%b an=%b required 1/0001", frame_done, an);
        end
      end
    end
  endtask

  task automatic test_midframe_load();
    int n;
    n = 0;
    while (!(m_scan && m_pos == CPD) && n < 64) begin tick(); n++; end
    checks++;
    if (n >= 64) begin failures++; $display("FAIL midframe_wait budget expired"); end
    din = 16'hABCD; load = 1'b1; tick(); load = 1'b0;
    n = 0;
    while (m_pos != 0 && n < 64) begin
      tick(); n++;
      checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== m_fd) begin
        failures++;
        $display("FAIL midframe_model pos=%0d an=%b/%b seg=%b/%b fd=%b/%b", m_pos, an, exp_an(), seg, exp_seg(), frame_done, m_fd);
      end
    end
    checks++;
    if (seg !== 7'b0111101 || an !== 4'b0001) begin
      failures++;
      $display("FAIL midframe_next seg=%b an=%b required 0111101/0001", seg, an);
    end
  endtask

  task automatic test_boundary_load();
    int n;
    n = 0;
    while (!(m_scan && m_pos == FRAME - 1) && n < 64) begin tick(); n++; end
    din = 16'h000F; load = 1'b1; tick(); load = 1'b0; din = 16'h5555;
    checks++;
    if (seg !== 7'b1000111 || an !== 4'b0001 || frame_done !== 1'b1) begin
      failures++;
      $display("FAIL boundary_bypass seg=%b an=%b fd=%b required 1000111/0001/1", seg, an, frame_done);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== m_fd) begin
        failures++;
        $display("FAIL boundary_model i=%0d an=%b/%b seg=%b/%b fd=%b/%b", i, an, exp_an(), seg, exp_seg(), frame_done, m_fd);
      end
    end
  endtask

  task automatic test_en_drop();
    int n;
    n = 0;
    while (!(m_scan && m_pos == 3 * CPD + 1) && n < 64) begin tick(); n++; end
    en = 1'b0; tick(); en = 1'b1;
    checks++;
    if (an !== 4'b0000 || seg !== 7'b0000000 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_idle an=%b seg=%b fd=%b required 0000/0000000/0", an, seg, frame_done);
    end
    for (int i = 0; i < FRAME + 2; i++) begin
      tick();
      checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== m_fd) begin
        failures++;
        $display("FAIL en_drop_model i=%0d an=%b/%b seg=%b/%b fd=%b/%b", i, an, exp_an(), seg, exp_seg(), frame_done, m_fd);
      end
      if (i < CPD) begin
        checks++;
        if (an !== 4'b0001 || frame_done !== 1'b0) begin
          failures++;
          $display("FAIL en_drop_restart i=%0d an=%b fd=%b required 0001/0", i, an, frame_done);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (!(m_scan && m_pos == 2 * CPD) && n < 64) begin tick(); n++; end
    din = 16'h9876; load = 1'b1; tick(); load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (an !== 4'b0000 || seg !== 7'b0000000 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset an=%b seg=%b fd=%b required 0000/0000000/0", an, seg, frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (an !== 4'b0001 || seg !== 7'b1111110) begin
      failures++;
      $display("FAIL reset_resume an=%b seg=%b required 0001/1111110", an, seg);
    end
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== m_fd) begin
        failures++;
        $display("FAIL reset_model i=%0d an=%b/%b seg=%b/%b fd=%b/%b", i, an, exp_an(), seg, exp_seg(), frame_done, m_fd);
      end
    end
  endtask

`ifdef SEG_SCAN_BLANK_EN
  task automatic test_blank();
    logic [6:0] req [4] = '{7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000};
    en = 1'b0; tick();
    din = 16'h0050; load = 1'b1; tick(); load = 1'b0;
    en = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      checks++;
      if (an !== (4'b0001 << (i / CPD)) || seg !== req[i / CPD]) begin
        failures++;
        $display("FAIL blank_0050 i=%0d an=%b seg=%b required seg=%b", i, an, seg, req[i / CPD]);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 15) != 0);
      load = ($urandom_range(0, 3) == 0);
      din  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : (16'($urandom) & 16'h00FF);
      tick();
      checks++;
      if (an !== exp_an() || seg !== exp_seg() || frame_done !== m_fd) begin
        failures++;
        $display("FAIL random i=%0d an=%b/%b seg=%b/%b fd=%b/%b", i, an, exp_an(), seg, exp_seg(), frame_done, m_fd);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_midframe_load();
    test_boundary_load();
    test_en_drop();
    test_async_reset();
`ifdef SEG_SCAN_BLANK_EN
    test_blank();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLKS_PER_DIGIT, default 1000, meaning clock cycles each digit is displayed (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1, scan enable.
REQ-005 The block SHALL have port load, input, 1, capture din this cycle.
REQ-006 The block SHALL have port din, input, 16, four hex digits; din[3:0] is digit 0 (rightmost), din[15:12] is digit 3.
REQ-007 The block SHALL have port seg, output, 7, active-high segments: seg[6]=a, seg[5]=b, ..., seg[0]=g.
REQ-008 The block SHALL have port an, output, 4, active-high one-hot digit select; an[i] selects digit i.
REQ-009 The block SHALL have port frame_done, output, 1, one-cycle pulse at each completed 4-digit frame.

Function
REQ-010 The block SHALL implement states IDLE and SCAN; IDLE->SCAN when en=1, SCAN->IDLE when en=0, both on the next edge.
REQ-011 In IDLE, the block SHALL hold an=4'b0000, seg=7'b0000000, frame_done=0, tick counter=0, digit index=0.
REQ-012 On IDLE->SCAN, the block SHALL copy the shadow register into the display register, start at digit 0 with tick=0, and assert an=4'b0001 in the first SCAN cycle.
REQ-013 A tick counter SHALL count 0..CLKS_PER_DIGIT-1 in SCAN. At terminal count it SHALL wrap to 0 and advance the digit index 0->1->2->3->0.
REQ-014 an and seg SHALL be registered outputs. Both SHALL change on the same edge as the digit index, with no intermediate value.
REQ-015 seg SHALL be the decode of display nibble [4i+3:4i] for current digit i, using this table (hex value: seg value):
- 0:1111110, 1:0110000, 2:1101101, 3:1111001
- 4:0110011, 5:1011011, 6:1011111, 7:1110000
- 8:1111111, 9:1111011, A:1110111, b:0011111
- C:1001110, d:0111101, E:1001111, F:1000111
REQ-016 When load=1, the block SHALL write din into the shadow register on that edge, in any state.
REQ-017 The display register SHALL update only at a frame boundary (digit 3 terminal count) or on IDLE->SCAN, so there is no mid-frame tearing.
REQ-018 If load=1 on the frame-boundary cycle, the display register SHALL take din directly (bypass), not the old shadow value.
REQ-019 frame_done SHALL be 1 for exactly the one cycle after the digit 3->0 advance edge, and 0 otherwise.
REQ-020 If en deasserts mid-frame, the block SHALL not pulse frame_done. The scan SHALL restart at digit 0 on re-enable.

Reset
REQ-021 While rst_n=0, the block SHALL immediately (asynchronously) force state=IDLE, an=0, seg=0, frame_done=0, tick=0, digit index=0, shadow=0, display=0.
REQ-022 After rst_n deasserts with en=1, the block SHALL enter SCAN on the first rising edge and show digit 0 value 0 (seg=1111110) from the following cycle.
REQ-023 Reset asserted mid-frame SHALL discard any pending shadow contents.

Configuration
REQ-024 With macro SEG_SCAN_BLANK_EN defined, the block SHALL blank leading zeros: for i=3..1, if nibble i and all higher nibbles are 0, seg=0000000 while an[i] is still asserted. Digit 0 SHALL never be blanked.
REQ-025 Without SEG_SCAN_BLANK_EN, the block SHALL decode all four digits per REQ-015. The blanking logic SHALL be absent.

Verification (CLKS_PER_DIGIT=4)
REQ-026 Scenario: load din=16'h1234, then en=1. Required response per digit, each held for 4 cycles:
- an=0001, seg=0110011
- an=0010, seg=1111001
- an=0100, seg=1101101
- an=1000, seg=0110000
- then frame_done pulses once.
REQ-027 Scenario: mid-frame (digit 1), load din=16'hABCD. Required response: digits 1..3 still show the old value; from the next frame, digit 0 shows seg=0111101.
REQ-028 Scenario: load=1 with din=16'h000F on the exact frame-boundary cycle. Required response: the next frame's digit 0 shows seg=1000111.
REQ-029 Scenario: SEG_SCAN_BLANK_EN defined, din=16'h0050. Required response:
- digits 3 and 2: seg=0000000
- digit 1: seg=1011011
- digit 0: seg=1111110
REQ-030 Scenario: assert rst_n=0 mid-digit 2. Required response: an=0000 and seg=0000000 in the same cycle, with no clock edge needed. After release, scan resumes at digit 0 showing 0.
REQ-031 Scenario: drop en for 1 cycle during digit 3. Required response: an=0000 and no frame_done pulse; on re-enable, an=0001 with the tick count restarted.
